hi_lo_unit: RTL and testbench
=============================

# hi_lo_unit

- Holds the architectural HI/LO register pair for the MIPS datapath.
- Closes the ALU's HiLo interface: accepts the 64-bit HiLoWrite/HiLoEn result from MULT/MULTU/MADD/MSUB and returns the current pair on HiLoRead for MADD/MSUB accumulation.
- Services MTHI/MTLO writes.
- Contains the iterative 32-cycle DIV/DIVU engine; its Busy output is used by hazard control to stall the pipeline.

## Interface
- HI_RESET, 32'h00000000, value loaded into HI on reset
- LO_RESET, 32'h00000000, value loaded into LO on reset
- Clk  input  1  clock; all state changes on rising edge
- Rst  input  1  synchronous, active-high reset
- HiLoEn  input  1  write HiLoWrite into {HI,LO} this edge
- HiLoWrite  input  64  [63:32]→HI, [31:0]→LO
- MoveHi  input  1  MTHI: HI ← MoveData
- MoveLo  input  1  MTLO: LO ← MoveData
- MoveData  input  32  rs value for MTHI/MTLO
- DivStart  input  1  start division (one-cycle pulse)
- DivSigned  input  1  1 = DIV, 0 = DIVU; sampled with DivStart
- DivA  input  32  dividend; sampled with DivStart
- DivB  input  32  divisor; sampled with DivStart
- HiLoRead  output  64  {HI,LO}, registered state, combinational read
- Hi  output  32  HI (MFHI source)
- Lo  output  32  LO (MFLO source)
- Busy  output  1  division in progress
- DivDone  output  1  one-cycle pulse on the edge HI/LO take the division result
- DivZero  output  1  one-cycle pulse with DivDone when the divisor was 0

## Operation
- States:
  - IDLE
  - CALC: counter 0..31
  - FIX
- Busy = (state != IDLE).
- IDLE write priority:
  - HiLoEn overrides MoveHi/MoveLo. HiLoEn writes both halves.
  - MoveHi and MoveLo together write both halves with MoveData.
- IDLE, DivStart=1:
  - Latch operands: magnitudes |DivA|, |DivB| when DivSigned, raw values otherwise.
  - Latch quotient sign (DivA[31]^DivB[31])&DivSigned, remainder sign DivA[31]&DivSigned, and divisor-zero flag.
  - Clear 33-bit partial remainder; → CALC, counter=0.
  - A HiLoEn/Move write in the same cycle is still performed.
- CALC, per cycle: restoring step.
  - rem = {rem[31:0], dvd[31]}; dvd <<= 1.
  - If rem >= divisor: rem -= divisor, quotient bit = 1; else 0.
  - counter==31 → FIX.
- FIX:
  - Divisor ≠ 0: LO ← quotient negated if quotient sign; HI ← remainder negated if remainder sign.
  - Assert DivDone; assert DivZero if divisor = 0. → IDLE.
- Divide by zero: HI/LO left unchanged; full 33-cycle latency still applies.
- 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
- While Busy:
  - DivStart, HiLoEn, MoveHi and MoveLo are ignored; no write, no restart.
  - Hazard control must stall these instructions.
- Hi/Lo/HiLoRead always reflect the committed registers. There is no bypass: a write is visible the cycle after its edge.
- Reset (any state, including mid-CALC):
  - HI=HI_RESET, LO=LO_RESET, state=IDLE.
  - Busy=0, DivDone=0, DivZero=0, counter=0; the in-flight division is discarded.

## Timing
- HiLoEn/Move write: one edge; new value on HiLoRead the following cycle.
- MADD/MSUB read-modify-write: HiLoRead is stable for the whole cycle; the result is written at the same edge. Back-to-back MADDs accumulate correctly.
- Division:
  - DivStart sampled at edge E0; Busy high from E0 until edge E0+33.
  - CALC occupies edges E0+1..E0+32; FIX is the cycle before E0+33.
  - HI/LO update at E0+33. DivDone/DivZero high for the one cycle following E0+32; Busy drops at E0+33.
  - A new DivStart is accepted in the first cycle with Busy=0.
- Outputs are registered or decoded from registered state; no combinational input→output path except none (HiLoRead is pure state).

## Test plan
- Reset mid-division: DivStart A=100 B=7, Rst at cycle 10 → Busy=0 next cycle, HI=LO=0, no DivDone ever.
- MULT then MADD: HiLoEn with 0x00000001_00000002, then HiLoEn with 0x00000001_00000003 → HiLoRead 0x0000000100000002 then 0x0000000100000003; MTHI 0xDEADBEEF alongside HiLoEn is ignored.
- DIVU 100/7: DivStart at E0 → Busy 33 cycles, at E0+33 LO=14, HI=2, DivDone pulse, DivZero=0.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: HI=0x11111111, LO=0x22222222, DIVU 5/0 → after 33 cycles HI/LO unchanged, DivDone=DivZero=1 for one cycle.
- Busy lockout: during division, pulse DivStart, HiLoEn, MoveLo → all ignored; final result matches the first division only.

Source files
------------

// File: rtl/hi_lo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hi_lo_unit
//  Description : Architectural HI/LO register pair for the MIPS datapath.
//                It takes 64-bit multiply/accumulate results from the ALU
//                (HiLoEn/HiLoWrite) and returns the current pair on HiLoRead
//                for MADD/MSUB. It also handles MTHI/MTLO writes. It contains
//                an iterative 32-step restoring DIV/DIVU engine, and raises
//                Busy so hazard control can stall the pipeline.
//  Ports       : Clk, Rst (sync, active-high)
//                HiLoEn, HiLoWrite[63:0]     - 64-bit pair write
//                MoveHi, MoveLo, MoveData    - MTHI / MTLO
//                DivStart, DivSigned, DivA, DivB - division launch
//                HiLoRead[63:0], Hi, Lo      - committed register state
//                Busy, DivDone, DivZero      - division status
//  Revision    : 1.0 - initial release
// ============================================================================
module hi_lo_unit #(
    parameter logic [31:0] HI_RESET = 32'h0000_0000,
    parameter logic [31:0] LO_RESET = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        HiLoEn,
    input  logic [63:0] HiLoWrite,
    input  logic        MoveHi,
    input  logic        MoveLo,
    input  logic [31:0] MoveData,
    input  logic        DivStart,
    input  logic        DivSigned,
    input  logic [31:0] DivA,
    input  logic [31:0] DivB,
    output logic [63:0] HiLoRead,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        DivDone,
    output logic        DivZero
);

    localparam logic [4:0] c_LAST_STEP = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [4:0]  r_cnt;
    logic [31:0] r_dvd;        // dividend shifts out the top, quotient shifts in the bottom
    logic [31:0] r_dvs;        // divisor magnitude
    logic [31:0] r_rem;        // partial remainder; always < divisor, so 32 bits hold it
    logic        r_q_neg;
    logic        r_r_neg;
    logic        r_dvs_zero;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_rem_shift;
    logic [32:0] w_rem_sub;
    logic        w_q_bit;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // ------------------------------------------------------------------------
    // Operand conditioning. For DIV, the engine works on magnitudes. The
    // magnitude of 0x80000000 is 0x80000000, which is still correct when it
    // is read as unsigned.
    // ------------------------------------------------------------------------
    always_comb begin
        w_abs_a = (DivSigned && DivA[31]) ? (32'd0 - DivA) : DivA;
        w_abs_b = (DivSigned && DivB[31]) ? (32'd0 - DivB) : DivB;
    end

    // One restoring step. The shifted remainder needs 33 bits before the
    // compare, because the previous remainder can be as large as 2^32-2.
    always_comb begin
        w_rem_shift = {r_rem, r_dvd[31]};
        w_rem_sub   = w_rem_shift - {1'b0, r_dvs};
        w_q_bit     = (w_rem_shift >= {1'b0, r_dvs});
    end

    // Sign fix-up of the final magnitudes.
    always_comb begin
        w_quo_fix = r_q_neg ? (32'd0 - r_dvd) : r_dvd;
        w_rem_fix = r_r_neg ? (32'd0 - r_rem) : r_rem;
    end

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (DivStart)              w_state_next = ST_CALC;
            ST_CALC: if (r_cnt == c_LAST_STEP)  w_state_next = ST_FIX;
            ST_FIX:                             w_state_next = ST_IDLE;
            default:                            w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Division datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt      <= 5'd0;
            r_dvd      <= 32'd0;
            r_dvs      <= 32'd0;
            r_rem      <= 32'd0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dvs_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (DivStart) begin
                        r_dvd      <= w_abs_a;
                        r_dvs      <= w_abs_b;
                        r_rem      <= 32'd0;
                        r_cnt      <= 5'd0;
                        r_q_neg    <= (DivA[31] ^ DivB[31]) & DivSigned;
                        r_r_neg    <= DivA[31] & DivSigned;
                        r_dvs_zero <= (DivB == 32'd0);
                    end
                end
                ST_CALC: begin
                    r_dvd <= {r_dvd[30:0], w_q_bit};
                    r_rem <= w_q_bit ? w_rem_sub[31:0] : w_rem_shift[31:0];
                    r_cnt <= r_cnt + 5'd1;
                end
                default: begin
                    r_cnt <= 5'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // HI/LO registers. Writes from the pipeline are accepted only in IDLE.
    // While Busy they are dropped, because hazard control stalls those
    // instructions. HiLoEn takes priority over the move instructions.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_hi <= HI_RESET;
            r_lo <= LO_RESET;
        end else if (r_state == ST_FIX) begin
            if (!r_dvs_zero) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end
        end else if (r_state == ST_IDLE) begin
            if (HiLoEn) begin
                r_hi <= HiLoWrite[63:32];
                r_lo <= HiLoWrite[31:0];
            end else begin
                if (MoveHi) r_hi <= MoveData;
                if (MoveLo) r_lo <= MoveData;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: pure registered state, with no bypass.
    // ------------------------------------------------------------------------
    assign HiLoRead = {r_hi, r_lo};
    assign Hi       = r_hi;
    assign Lo       = r_lo;
    assign Busy     = (r_state != ST_IDLE);
    assign DivDone  = (r_state == ST_FIX);
    assign DivZero  = (r_state == ST_FIX) && r_dvs_zero;

endmodule
`default_nettype wire

// File: tb/tb_hi_lo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hi_lo_unit
//  Description : Self-checking bench for hi_lo_unit. Directed stimulus pushes
//                the expected division results into a scoreboard queue. A
//                monitor pops an entry on each DivDone pulse and compares the
//                status, the latency and the committed HI/LO pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hi_lo_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        HiLoEn;
    logic [63:0] HiLoWrite;
    logic        MoveHi;
    logic        MoveLo;
    logic [31:0] MoveData;
    logic        DivStart;
    logic        DivSigned;
    logic [31:0] DivA;
    logic [31:0] DivB;
    logic [63:0] HiLoRead;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        DivDone;
    logic        DivZero;

    hi_lo_unit #(
        .HI_RESET (32'h0000_0000),
        .LO_RESET (32'h0000_0000)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .HiLoEn    (HiLoEn),
        .HiLoWrite (HiLoWrite),
        .MoveHi    (MoveHi),
        .MoveLo    (MoveLo),
        .MoveData  (MoveData),
        .DivStart  (DivStart),
        .DivSigned (DivSigned),
        .DivA      (DivA),
        .DivB      (DivB),
        .HiLoRead  (HiLoRead),
        .Hi        (Hi),
        .Lo        (Lo),
        .Busy      (Busy),
        .DivDone   (DivDone),
        .DivZero   (DivZero)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic        zero;
        logic [63:0] hilo;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks    = 0;
    int   fails     = 0;
    int   done_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: sample on the falling edge, away from the active edge
    // ------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge Clk);
            if (DivDone === 1'b1) begin
                done_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_divdone: got DivDone=1 at cycle %0d expected none", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("div_zero_flag", {63'd0, DivZero}, {63'd0, mon_e.zero});
                    chk("div_done_latency", 64'(cyc), 64'(mon_e.done_cyc));
                    @(negedge Clk);
                    chk("div_result_hilo", HiLoRead, mon_e.hilo);
                    chk("div_done_one_cycle", {63'd0, DivDone}, 64'd0);
                    chk("busy_dropped", {63'd0, Busy}, 64'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge)
    // ------------------------------------------------------------------------
    task automatic wr(input logic en, input logic mh, input logic ml,
                      input logic [31:0] data, input logic [63:0] wval,
                      input logic [63:0] exp, input string name);
        HiLoEn    = en;
        HiLoWrite = wval;
        MoveHi    = mh;
        MoveLo    = ml;
        MoveData  = data;
        @(negedge Clk);
        HiLoEn = 1'b0;
        MoveHi = 1'b0;
        MoveLo = 1'b0;
        chk(name, HiLoRead, exp);
        chk({name, "_hi"}, {32'd0, Hi}, {32'd0, exp[63:32]});
        chk({name, "_lo"}, {32'd0, Lo}, {32'd0, exp[31:0]});
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic [63:0] exp_hilo, input logic zero,
                           input bit lockout, input bit cw, input logic [63:0] cw_val);
        int busy_cnt;
        DivStart  = 1'b1;
        DivSigned = sgn;
        DivA      = a;
        DivB      = b;
        HiLoEn    = cw;
        HiLoWrite = cw_val;
        sb.push_back('{zero: zero, hilo: exp_hilo, done_cyc: cyc + 33});
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            DivStart = 1'b0;
            HiLoEn   = 1'b0;
            MoveLo   = 1'b0;
            if (i == 0 && cw) chk("write_with_divstart", HiLoRead, cw_val);
            if (!Busy) break;
            busy_cnt++;
            if (lockout && busy_cnt == 5) begin
                DivStart  = 1'b1;
                DivSigned = 1'b0;
                DivA      = 32'd50;
                DivB      = 32'd5;
                HiLoEn    = 1'b1;
                HiLoWrite = 64'h5555_5555_6666_6666;
                MoveLo    = 1'b1;
                MoveData  = 32'h7777_7777;
            end
        end
        chk("busy_cycles", 64'(busy_cnt), 64'd33);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int done_before;
        Rst       = 1'b1;
        HiLoEn    = 1'b0;
        HiLoWrite = 64'd0;
        MoveHi    = 1'b0;
        MoveLo    = 1'b0;
        MoveData  = 32'd0;
        DivStart  = 1'b0;
        DivSigned = 1'b0;
        DivA      = 32'd0;
        DivB      = 32'd0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        chk("reset_hilo", HiLoRead, 64'd0);
        chk("reset_busy", {63'd0, Busy}, 64'd0);
        chk("reset_divdone", {63'd0, DivDone}, 64'd0);

        // MULT then MADD; MTHI alongside HiLoEn loses
        wr(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 64'h0000_0001_0000_0002, 64'h0000_0001_0000_0002, "mult_write");
        wr(1'b1, 1'b0, 1'b0, 32'h0,         64'h0000_0001_0000_0003, 64'h0000_0001_0000_0003, "madd_write");
        wr(1'b0, 1'b1, 1'b0, 32'hAAAA_5555, 64'h0, 64'hAAAA_5555_0000_0003, "mthi");
        wr(1'b0, 1'b0, 1'b1, 32'h1234_5678, 64'h0, 64'hAAAA_5555_1234_5678, "mtlo");
        wr(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 64'h0, 64'hCAFE_F00D_CAFE_F00D, "mthi_mtlo");

        // DIVU 100/7 -> q=14, r=2
        run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0, 0, 0, 64'd0);
        // DIV -7/2 -> q=-3, r=-1
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 0, 0, 64'd0);
        // DIV 0x80000000 / -1 -> q=0x80000000, r=0
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 1'b0, 0, 0, 64'd0);
        // DIV 7/-2 with a same-cycle HiLoEn write -> q=-3, r=1
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 1'b0, 0, 1, 64'h0BAD_CAFE_0000_1234);

        // Divide by zero leaves HI/LO untouched
        wr(1'b1, 1'b0, 1'b0, 32'h0, 64'h1111_1111_2222_2222, 64'h1111_1111_2222_2222, "preload");
        run_div(32'd5, 32'd0, 1'b0, 64'h1111_1111_2222_2222, 1'b1, 0, 0, 64'd0);

        // Busy lockout: DIVU 1000/3 -> q=333, r=1, with stray writes/restart mid-flight
        run_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 1'b0, 1, 0, 64'd0);

        // Let the monitor drain the scoreboard
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge Clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        // Reset in mid-division
        DivStart  = 1'b1;
        DivSigned = 1'b0;
        DivA      = 32'd100;
        DivB      = 32'd7;
        @(negedge Clk);
        DivStart = 1'b0;
        repeat (9) @(negedge Clk);
        chk("busy_before_reset", {63'd0, Busy}, 64'd1);
        done_before = done_seen;
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("reset_mid_busy", {63'd0, Busy}, 64'd0);
        chk("reset_mid_hilo", HiLoRead, 64'd0);
        chk("reset_mid_divdone", {63'd0, DivDone}, 64'd0);
        repeat (40) @(negedge Clk);
        chk("no_divdone_after_reset", 64'(done_seen), 64'(done_before));
        chk("idle_after_reset", {63'd0, Busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
